snoop_bus_ctrl: RTL and testbench

//  Shared snooping-bus controller that sits below the per-processor cache/MESI stage and above the shared memory.
//  - Consumes bus requests raised by each processor's MESI outputs (read miss, write miss, invalidate).
//  - Arbitrates round-robin among requesters and broadcasts one snoop per transaction.
//  - Collects abort/write-back from the owning cache, writes the owner's data back to memory, then returns the fill data.

---
 rtl/snoop_bus_pkg.sv | 28 ++
 rtl/snoop_bus_rr_arbiter.sv | 28 ++
 rtl/snoop_bus_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_snoop_bus_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snoop_bus_pkg.sv
// Shared definitions for the snooping-bus controller: bus op codes,
// MESI line-state encoding, controller FSM states and a counter helper.
package snoop_bus_pkg;

  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_RD   = 2'd1;
  localparam logic [1:0] BUS_RDX  = 2'd2;
  localparam logic [1:0] BUS_UPGR = 2'd3;

  localparam logic [1:0] MESI_I = 2'd0;
  localparam logic [1:0] MESI_S = 2'd1;
  localparam logic [1:0] MESI_M = 2'd2;
  localparam logic [1:0] MESI_E = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_SNOOP = 3'd2,
    ST_WB    = 3'd3,
    ST_MEM   = 3'd4,
    ST_DONE  = 3'd5
  } bus_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/snoop_bus_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request at or
// after the pointer, wrapping around. The pointer register lives in the caller.
module rr_arbiter #(
  parameter int N_PROC = 3,
  parameter int PTR_W  = 2
) (
  input  logic [N_PROC-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  output logic [N_PROC-1:0] gnt
);

  // Scan requesters starting at the pointer and pick the first one found
  always_comb begin
    int idx;
    logic found;
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_PROC; k++) begin
      idx = (int'(ptr) + k) % N_PROC;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/snoop_bus_ctrl.sv
// Snooping-bus controller: round-robin arbitration of processor bus requests,
// one snoop broadcast per transaction, owner write-back or memory fill, then a
// one-cycle done pulse. Optional statistics counters are compiled in when the
// macro SNOOP_BUS_STATS_EN is defined.
module snoop_bus_ctrl
  import snoop_bus_pkg::*;
#(
  parameter int N_PROC  = 3,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_PROC-1:0]        req,
  input  logic [2*N_PROC-1:0]      req_op,
  input  logic [ADDR_W*N_PROC-1:0] req_addr,
  output logic [N_PROC-1:0]        gnt,
  output logic [N_PROC-1:0]        done,
  output logic [DATA_W-1:0]        rdata,
  output logic                     rdata_shared,
  output logic                     snp_valid,
  output logic [1:0]               snp_op,
  output logic [ADDR_W-1:0]        snp_addr,
  output logic [N_PROC-1:0]        snp_src,
  input  logic [N_PROC-1:0]        snp_hit,
  input  logic [N_PROC-1:0]        snp_abort,
  input  logic [DATA_W*N_PROC-1:0] snp_wb_data,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
`ifdef SNOOP_BUS_STATS_EN
  output logic [15:0]              stat_txn,
  output logic [15:0]              stat_wb,
`endif
  output logic                     err_multi
);

  localparam int PTR_W = (N_PROC > 1) ? $clog2(N_PROC) : 1;
  localparam int CNT_W = $clog2(MEM_LAT + 1);

  bus_state_t          state;
  logic [PTR_W-1:0]    ptr;
  logic [PTR_W-1:0]    cur_idx;
  logic [1:0]          cur_op;
  logic [ADDR_W-1:0]   cur_addr;
  logic [CNT_W-1:0]    lat_cnt;

  logic [N_PROC-1:0]   vreq;
  logic [N_PROC-1:0]   arb_gnt;
  logic [PTR_W-1:0]    arb_idx;
  logic [1:0]          sel_op;
  logic [ADDR_W-1:0]   sel_addr;
  logic [N_PROC-1:0]   abort_m;
  logic                abort_multi;
  logic [DATA_W-1:0]   owner_data;

  // Requests carrying op NONE never compete for the bus
  always_comb begin
    vreq = '0;
    for (int i = 0; i < N_PROC; i++)
      vreq[i] = req[i] && (req_op[2*i +: 2] != BUS_NONE);
  end

  rr_arbiter #(.N_PROC(N_PROC), .PTR_W(PTR_W)) u_arb (
    .req (vreq),
    .ptr (ptr),
    .gnt (arb_gnt)
  );

  // Decode the winning requester's index, op and address
  always_comb begin
    arb_idx  = '0;
    sel_op   = BUS_NONE;
    sel_addr = '0;
    for (int i = 0; i < N_PROC; i++) begin
      if (arb_gnt[i]) begin
        arb_idx  = PTR_W'(i);
        sel_op   = req_op[2*i +: 2];
        sel_addr = req_addr[ADDR_W*i +: ADDR_W];
      end
    end
  end

  // Pick the lowest-index aborting snooper as data owner; flag multiple owners
  always_comb begin
    logic found;
    abort_m     = snp_abort & ~snp_src;
    abort_multi = 1'b0;
    owner_data  = '0;
    found       = 1'b0;
    for (int i = 0; i < N_PROC; i++) begin
      if (abort_m[i]) begin
        if (found) begin
          abort_multi = 1'b1;
        end else begin
          owner_data = snp_wb_data[DATA_W*i +: DATA_W];
          found      = 1'b1;
        end
      end
    end
  end

  // Transaction FSM with all bus, memory and completion outputs registered
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      ptr          <= '0;
      cur_idx      <= '0;
      cur_op       <= BUS_NONE;
      cur_addr     <= '0;
      lat_cnt      <= '0;
      gnt          <= '0;
      done         <= '0;
      rdata        <= '0;
      rdata_shared <= 1'b0;
      snp_valid    <= 1'b0;
      snp_op       <= BUS_NONE;
      snp_addr     <= '0;
      snp_src      <= '0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      err_multi    <= 1'b0;
    end else begin
      done <= '0;
      case (state)
        ST_IDLE: begin
          if (|vreq) begin
            cur_idx  <= arb_idx;
            cur_op   <= sel_op;
            cur_addr <= sel_addr;
            gnt      <= arb_gnt;
            state    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          snp_valid    <= 1'b1;
          snp_op       <= cur_op;
          snp_addr     <= cur_addr;
          snp_src      <= gnt;
          rdata        <= '0;
          rdata_shared <= 1'b0;
          state        <= ST_SNOOP;
        end
        ST_SNOOP: begin
          snp_valid    <= 1'b0;
          snp_op       <= BUS_NONE;
          snp_addr     <= '0;
          snp_src      <= '0;
          rdata_shared <= (cur_op == BUS_RD) && (|(snp_hit & ~snp_src));
          if (abort_multi)
            err_multi <= 1'b1;
          if (|abort_m) begin
            // Owner's dirty/exclusive line goes to memory and straight to the requester
            mem_en    <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= cur_addr;
            mem_wdata <= owner_data;
            rdata     <= owner_data;
            state     <= ST_WB;
          end else if (cur_op == BUS_UPGR) begin
            done  <= gnt;
            state <= ST_DONE;
          end else begin
            mem_en   <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= cur_addr;
            lat_cnt  <= '0;
            state    <= ST_MEM;
          end
        end
        ST_WB: begin
          mem_en    <= 1'b0;
          mem_we    <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
          done      <= gnt;
          state     <= ST_DONE;
        end
        ST_MEM: begin
          // Single read strobe, then wait out the memory's registered latency
          mem_en <= 1'b0;
          if (lat_cnt == CNT_W'(MEM_LAT)) begin
            rdata    <= mem_rdata;
            mem_addr <= '0;
            done     <= gnt;
            state    <= ST_DONE;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          gnt   <= '0;
          ptr   <= (cur_idx == PTR_W'(N_PROC - 1)) ? '0 : cur_idx + 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SNOOP_BUS_STATS_EN
  // Saturating counts of completed transactions and owner write-backs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_txn <= '0;
      stat_wb  <= '0;
    end else begin
      if (state == ST_DONE)
        stat_txn <= sat_inc16(stat_txn);
      if (state == ST_WB)
        stat_wb <= sat_inc16(stat_wb);
    end
  end
`endif

endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// Scoreboard bench for snoop_bus_ctrl: a transaction-level model predicts the
// grant order, snoop broadcasts and completions; snooper and completion
// monitors run alongside the stimulus and pop expectations from queues.
module tb_snoop_bus_ctrl;

  localparam int N = 3, AW = 5, DW = 8, LAT = 1;
  localparam logic [1:0] OP_NONE = 2'd0, OP_RD = 2'd1, OP_RDX = 2'd2, OP_UPGR = 2'd3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0]    req = '0;
  logic [2*N-1:0]  req_op = '0;
  logic [AW*N-1:0] req_addr = '0;
  logic [N-1:0]    gnt, done;
  logic [DW-1:0]   rdata;
  logic            rdata_shared;
  logic            snp_valid;
  logic [1:0]      snp_op;
  logic [AW-1:0]   snp_addr;
  logic [N-1:0]    snp_src;
  logic [N-1:0]    snp_hit = '0;
  logic [N-1:0]    snp_abort = '0;
  logic [DW*N-1:0] snp_wb_data = '0;
  logic            mem_en, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata = '0;
  logic            err_multi;

  snoop_bus_ctrl #(.N_PROC(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clock(clock), .reset(reset), .req(req), .req_op(req_op), .req_addr(req_addr),
    .gnt(gnt), .done(done), .rdata(rdata), .rdata_shared(rdata_shared),
    .snp_valid(snp_valid), .snp_op(snp_op), .snp_addr(snp_addr), .snp_src(snp_src),
    .snp_hit(snp_hit), .snp_abort(snp_abort), .snp_wb_data(snp_wb_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .err_multi(err_multi)
  );

  always #5 clock = ~clock;

  logic [41:0] outs;
  assign outs = {gnt, done, rdata, rdata_shared, snp_valid, snp_op, snp_addr, snp_src,
                 mem_en, mem_we, mem_addr, mem_wdata, err_multi};

  // ---------------- memory model (environment) ----------------
  logic [DW-1:0] bmem [32];
  bit            bmem_v [32];
  int            rd_cnt = 0, wr_cnt = 0;

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return 8'h36 ^ {3'b000, a};
  endfunction

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    return bmem_v[a] ? bmem[a] : init_val(a);
  endfunction

  always @(posedge clock) begin
    if (mem_en && mem_we) begin
      bmem[mem_addr]   <= mem_wdata;
      bmem_v[mem_addr] <= 1'b1;
      wr_cnt           <= wr_cnt + 1;
    end
    if (mem_en && !mem_we) begin
      mem_rdata <= mem_val(mem_addr);
      rd_cnt    <= rd_cnt + 1;
    end
  end

  // ---------------- reference model state ----------------
  typedef struct {
    int            src;
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic [N-1:0]  hit;
    logic [N-1:0]  abort;
    logic [DW*N-1:0] wb;
  } plan_t;

  typedef struct {
    int          src;
    logic [DW-1:0] data;
    bit          chk;
    bit          shared;
    int          reads;
    int          writes;
  } exp_t;

  plan_t snoop_q[$];
  exp_t  sb_q[$];
  logic [N-1:0]    plan_hit [N];
  logic [N-1:0]    plan_abort [N];
  logic [DW*N-1:0] plan_wb [N];
  logic [DW-1:0]   ref_d [32];
  bit              ref_v [32];
  int  model_ptr = 0;
  bit  exp_err = 0;
  bit  fin = 0;
  int  rd_last = 0, wr_last = 0;
  int  n_checks = 0, n_pass = 0;

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_v[a] ? ref_d[a] : init_val(a);
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic clear_plans();
    for (int i = 0; i < N; i++) begin
      plan_hit[i] = '0; plan_abort[i] = '0; plan_wb[i] = '0;
    end
  endtask

  // Predict the whole round from round-robin order, then drive it and drop
  // each request once its completion is seen.
  task automatic run_round(input logic [N-1:0] rq, input logic [2*N-1:0] ops,
                           input logic [AW*N-1:0] addrs, input int exp_lat);
    logic [N-1:0] act, pending;
    int cyc, last, j, i;
    bit first;
    plan_t p;
    exp_t e;
    @(negedge clock);
    act = '0;
    for (int k = 0; k < N; k++)
      if (rq[k] && ops[2*k +: 2] != OP_NONE) act[k] = 1'b1;
    last = -1;
    for (int k = 0; k < N; k++) begin
      i = (model_ptr + k) % N;
      if (act[i]) begin
        p.src   = i;
        p.op    = ops[2*i +: 2];
        p.addr  = addrs[AW*i +: AW];
        p.abort = plan_abort[i] & ~(N'(1) << i);
        p.hit   = (plan_hit[i] | p.abort) & ~(N'(1) << i);
        p.wb    = plan_wb[i];
        e.src    = i;
        e.shared = (p.op == OP_RD) && (p.hit != '0);
        e.reads  = 0;
        e.writes = 0;
        e.chk    = 1;
        e.data   = '0;
        if (p.abort != '0) begin
          j = 0;
          while (!p.abort[j]) j++;
          e.data = p.wb[DW*j +: DW];
          e.writes = 1;
          ref_d[p.addr] = e.data;
          ref_v[p.addr] = 1'b1;
          if ($countones(p.abort) > 1) exp_err = 1'b1;
        end else if (p.op == OP_UPGR) begin
          e.chk = 0;
        end else begin
          e.data  = ref_rd(p.addr);
          e.reads = 1;
        end
        snoop_q.push_back(p);
        sb_q.push_back(e);
        last = i;
      end
    end
    if (last >= 0) model_ptr = (last + 1) % N;
    req = rq; req_op = ops; req_addr = addrs;
    pending = act;
    cyc = 0;
    first = 1'b1;
    if (act == '0) repeat (8) @(negedge clock);
    while (pending != '0 && cyc < 100) begin
      @(negedge clock);
      cyc++;
      if ((done & pending) != '0) begin
        if (first && exp_lat >= 0) chk("latency", cyc, exp_lat);
        first = 1'b0;
        pending &= ~done;
        req &= ~done;
      end
    end
    if (pending != '0) chk("round_timeout", pending, 0);
    req = '0; req_op = '0; req_addr = '0;
  endtask

  initial begin
    plan_t sp;
    exp_t  me;
    fork
      // ---------------- snooper: answer each broadcast from its plan ----------------
      begin
        while (!fin) begin
          @(negedge clock);
          if (snp_valid) begin
            if (snoop_q.size() == 0) begin
              chk("snoop_unexpected", snp_src, 0);
            end else begin
              sp = snoop_q.pop_front();
              chk("snoop_src", snp_src, N'(1) << sp.src);
              chk("snoop_op", snp_op, sp.op);
              chk("snoop_addr", snp_addr, sp.addr);
              snp_hit = sp.hit; snp_abort = sp.abort; snp_wb_data = sp.wb;
            end
          end else begin
            snp_hit = N'($urandom); snp_abort = N'($urandom); snp_wb_data = (DW*N)'($urandom);
          end
        end
      end
      // ---------------- completion monitor ----------------
      begin
        while (!fin) begin
          @(negedge clock);
          if (done != '0) begin
            if (sb_q.size() == 0) begin
              chk("done_unexpected", done, 0);
            end else begin
              me = sb_q.pop_front();
              chk("done_vec", done, N'(1) << me.src);
              if (me.chk) chk("rdata", rdata, me.data);
              chk("rdata_shared", rdata_shared, me.shared);
              chk("mem_reads", rd_cnt - rd_last, me.reads);
              chk("mem_writes", wr_cnt - wr_last, me.writes);
            end
            rd_last = rd_cnt;
            wr_last = wr_cnt;
          end
        end
      end
      // ---------------- stimulus ----------------
      begin
        int cyc;
        int mism;
        logic [N-1:0] rq;
        logic [2*N-1:0] ops;
        logic [AW*N-1:0] addrs;
        plan_t rp;
        clear_plans();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk("reset_outputs", outs, 0);
        reset = 1'b0;

        // P1 RD 0A, no sharers: memory fill
        run_round(3'b010, {OP_NONE, OP_RD, OP_NONE}, {5'h00, 5'h0A, 5'h00}, 4 + LAT);
        // P0 RD 0A, P2 shares
        clear_plans(); plan_hit[0] = 3'b100;
        run_round(3'b001, {OP_NONE, OP_NONE, OP_RD}, {5'h00, 5'h00, 5'h0A}, 4 + LAT);
        // P2 RDX 11, P0 owns and writes back A5
        clear_plans(); plan_abort[2] = 3'b001; plan_wb[2] = {8'h00, 8'h00, 8'hA5};
        run_round(3'b100, {OP_RDX, OP_NONE, OP_NONE}, {5'h11, 5'h00, 5'h00}, 4);
        // P1 UPGR 04, no owner
        clear_plans();
        run_round(3'b010, {OP_NONE, OP_UPGR, OP_NONE}, {5'h00, 5'h04, 5'h00}, -1);

        // Reset while the memory read is outstanding
        @(negedge clock);
        rp.src = 1; rp.op = OP_RD; rp.addr = 5'h07; rp.hit = '0; rp.abort = '0; rp.wb = '0;
        snoop_q.push_back(rp);
        req = 3'b010; req_op = {OP_NONE, OP_RD, OP_NONE}; req_addr = {5'h00, 5'h07, 5'h00};
        cyc = 0;
        while (!mem_en && cyc < 20) begin @(negedge clock); cyc++; end
        chk("reach_mem", mem_en, 1);
        reset = 1'b1;
        #1;
        chk("reset_mid_outputs", outs, 0);
        repeat (3) begin @(negedge clock); chk("no_done_in_reset", done, 0); end
        req = '0; req_op = '0; req_addr = '0;
        @(negedge clock);
        reset = 1'b0;
        rd_last = rd_cnt; wr_last = wr_cnt;
        exp_err = 1'b0; model_ptr = 0;
        sb_q.delete(); snoop_q.delete();
        // Pointer restarts at 0: P0 must beat P2
        run_round(3'b101, {OP_RD, OP_NONE, OP_RD}, {5'h02, 5'h00, 5'h01}, -1);
        // All three request together, then P0 again
        run_round(3'b111, {OP_RD, OP_RD, OP_RD}, {5'h03, 5'h0A, 5'h11}, -1);
        run_round(3'b001, {OP_NONE, OP_NONE, OP_RD}, {5'h00, 5'h00, 5'h04}, 4 + LAT);
        // Two owners: lowest index (P1) supplies the line
        plan_abort[0] = 3'b110; plan_wb[0] = {8'h77, 8'h5E, 8'h00};
        run_round(3'b001, {OP_NONE, OP_NONE, OP_RDX}, {5'h00, 5'h00, 5'h03}, 4);

        // Randomized rounds over a small address window
        for (int r = 0; r < 60; r++) begin
          for (int i = 0; i < N; i++) begin
            plan_hit[i] = N'($urandom);
            case ($urandom_range(0, 3))
              2: plan_abort[i] = N'(1) << $urandom_range(0, N - 1);
              3: plan_abort[i] = N'($urandom);
              default: plan_abort[i] = '0;
            endcase
            plan_wb[i] = (DW*N)'($urandom);
          end
          rq = N'($urandom);
          ops = (2*N)'($urandom);
          for (int i = 0; i < N; i++) addrs[AW*i +: AW] = AW'($urandom_range(0, 7));
          run_round(rq, ops, addrs, -1);
        end

        @(negedge clock);
        chk("err_multi", err_multi, exp_err);
        mism = 0;
        for (int a = 0; a < 32; a++)
          if (mem_val(AW'(a)) != ref_rd(AW'(a))) mism++;
        chk("memory_image", mism, 0);
        chk("queues_drained", sb_q.size() + snoop_q.size(), 0);
        fin = 1'b1;
      end
    join
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
